// File: rtl/fetch_queue_phase.sv
// Fetch-side queue: qualifies returning instruction-memory words against the
// in-flight vector, buffers them for decode and requests a PC replay on overflow.
module fetch_queue_phase #(
    parameter int unsigned LOAD_LATENCY = 1,
    parameter int unsigned QUEUE_DEPTH  = 4,
    parameter int unsigned INST_W       = 32,
    parameter int unsigned ADDR_W       = 32
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [INST_W-1:0]              inst_from_mem,
    input  logic [ADDR_W-1:0]              pc_to_fet,
    input  logic                           flush,
    output logic                           stall_pc,
    output logic                           fd_valid,
    output logic [INST_W-1:0]              fd_inst,
    output logic [ADDR_W-1:0]              fd_pc,
    input  logic                           fd_ready,
    output logic [$clog2(QUEUE_DEPTH):0]   q_count
);

    localparam int unsigned PtrW = $clog2(QUEUE_DEPTH);
    localparam int unsigned CntW = PtrW + 1;
    localparam logic [CntW-1:0] DepthC = CntW'(QUEUE_DEPTH);

    logic [LOAD_LATENCY-1:0] ifv_q, ifv_d;
    logic [PtrW-1:0]         rptr_q, rptr_d;
    logic [PtrW-1:0]         wptr_q, wptr_d;
    logic [CntW-1:0]         count_q, count_d;

    logic [INST_W-1:0]       inst_mem_q [QUEUE_DEPTH];
    logic [ADDR_W-1:0]       pc_mem_q   [QUEUE_DEPTH];

    logic ret_v;
    logic push;
    logic pop;

    // A returning word is genuine only if its read was issued after the last redirect.
    assign ret_v    = ifv_q[LOAD_LATENCY-1] & ~flush;
    assign pop      = fd_valid & fd_ready;
    assign push     = ret_v & ((count_q < DepthC) | pop);
    assign stall_pc = ret_v & ~push;

    always_comb begin
        ifv_d = '0;
        if (!(flush || stall_pc)) begin
            ifv_d[0] = 1'b1;
            for (int i = 1; i < LOAD_LATENCY; i++) begin
                ifv_d[i] = ifv_q[i-1];
            end
        end
    end

    always_comb begin
        rptr_d  = rptr_q;
        wptr_d  = wptr_q;
        count_d = count_q;
        if (flush) begin
            rptr_d  = '0;
            wptr_d  = '0;
            count_d = '0;
        end else begin
            if (push) begin
                wptr_d = wptr_q + PtrW'(1);
            end
            if (pop) begin
                rptr_d = rptr_q + PtrW'(1);
            end
            count_d = count_q + CntW'(push) - CntW'(pop);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ifv_q   <= '0;
            rptr_q  <= '0;
            wptr_q  <= '0;
            count_q <= '0;
        end else begin
            ifv_q   <= ifv_d;
            rptr_q  <= rptr_d;
            wptr_q  <= wptr_d;
            count_q <= count_d;
        end
    end

    // Storage needs no reset: slots are only read while counted as occupied.
    always_ff @(posedge clk) begin
        if (push) begin
            inst_mem_q[wptr_q] <= inst_from_mem;
            pc_mem_q[wptr_q]   <= pc_to_fet;
        end
    end

    assign fd_valid = (count_q != '0);
    assign fd_inst  = inst_mem_q[rptr_q];
    assign fd_pc    = pc_mem_q[rptr_q];
    assign q_count  = count_q;

endmodule

// File: tb/tb_fetch_queue_phase.sv
// Directed bench: one LOAD_LATENCY=1 and one LOAD_LATENCY=2 instance, each fed by
// a small write-back/memory model, with an in-order pop checker per instance.
module tb_fetch_queue_phase;

    localparam int unsigned AW = 32;
    localparam int unsigned IW = 32;
    localparam logic [AW-1:0] TgtA = 32'h0000_0100;
    localparam logic [AW-1:0] TgtB = 32'h0000_0040;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic [IW-1:0] inst_a, fdi_a, inst_b, fdi_b;
    logic [AW-1:0] pc_fet_a, fdp_a, pc_fet_b, fdp_b;
    logic          flush_a = 1'b0, flush_b = 1'b0;
    logic          ready_a = 1'b1, ready_b = 1'b0;
    logic          stall_a, stall_b, fdv_a, fdv_b;
    logic [2:0]    qc_a, qc_b;

    logic [AW-1:0] wb_a, pcq_a, wb_b, pcq0_b, pcq1_b;
    logic [AW-1:0] exp_a = '0, exp_b = '0;
    int            pops_a = 0;
    int            n_checks = 0;
    int            n_errors = 0;

    always #5 clk = ~clk;

    function automatic logic [IW-1:0] inst_of(input logic [AW-1:0] pc);
        return {pc[15:0] ^ 16'hBEEF, pc[15:0]};
    endfunction

    assign pc_fet_a = pcq_a;
    assign inst_a   = inst_of(pc_fet_a);
    assign pc_fet_b = pcq1_b;
    assign inst_b   = inst_of(pc_fet_b);

    fetch_queue_phase #(.LOAD_LATENCY(1), .QUEUE_DEPTH(4), .INST_W(IW), .ADDR_W(AW)) u_a (
        .clk(clk), .rst(rst), .inst_from_mem(inst_a), .pc_to_fet(pc_fet_a),
        .flush(flush_a), .stall_pc(stall_a), .fd_valid(fdv_a), .fd_inst(fdi_a),
        .fd_pc(fdp_a), .fd_ready(ready_a), .q_count(qc_a)
    );

    fetch_queue_phase #(.LOAD_LATENCY(2), .QUEUE_DEPTH(4), .INST_W(IW), .ADDR_W(AW)) u_b (
        .clk(clk), .rst(rst), .inst_from_mem(inst_b), .pc_to_fet(pc_fet_b),
        .flush(flush_b), .stall_pc(stall_b), .fd_valid(fdv_b), .fd_inst(fdi_b),
        .fd_pc(fdp_b), .fd_ready(ready_b), .q_count(qc_b)
    );

    // Write-back model: sequential PC, redirect on flush, replay on stall.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_a   <= '0;
            pcq_a  <= '0;
            wb_b   <= '0;
            pcq0_b <= '0;
            pcq1_b <= '0;
        end else begin
            pcq_a  <= wb_a;
            wb_a   <= flush_a ? TgtA : (stall_a ? pc_fet_a : wb_a + 1);
            pcq0_b <= wb_b;
            pcq1_b <= pcq0_b;
            wb_b   <= flush_b ? TgtB : (stall_b ? pc_fet_b : wb_b + 1);
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Decode-side checker: every accepted word must be the next PC in sequence.
    initial forever begin
        @(negedge clk or posedge rst);
        if (rst) begin
            exp_a  = '0;
            exp_b  = '0;
            pops_a = 0;
        end else begin
            if (flush_a) begin
                exp_a = TgtA;
            end else if (fdv_a && ready_a) begin
                chk("a_pop_pc", 64'(fdp_a), 64'(exp_a));
                chk("a_pop_inst", 64'(fdi_a), 64'(inst_of(exp_a)));
                exp_a  = exp_a + 1;
                pops_a = pops_a + 1;
            end
            if (flush_b) begin
                exp_b = TgtB;
            end else if (fdv_b && ready_b) begin
                chk("b_pop_pc", 64'(fdp_b), 64'(exp_b));
                chk("b_pop_inst", 64'(fdi_b), 64'(inst_of(exp_b)));
                exp_b = exp_b + 1;
            end
        end
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_a_q", 64'(qc_a), 0);
        chk("rst_a_valid", 64'(fdv_a), 0);
        chk("rst_a_stall", 64'(stall_a), 0);
        chk("rst_b_q", 64'(qc_b), 0);
        chk("rst_b_valid", 64'(fdv_b), 0);
        rst = 1'b0;

        // Startup (A) and fill (B)
        tick(); #1;
        chk("c1_a_valid", 64'(fdv_a), 0);
        chk("c1_a_q", 64'(qc_a), 0);
        chk("c1_a_stall", 64'(stall_a), 0);
        tick(); #1;
        chk("c2_a_valid", 64'(fdv_a), 1);
        chk("c2_a_pc", 64'(fdp_a), 0);
        chk("c2_a_q", 64'(qc_a), 1);
        chk("c2_a_stall", 64'(stall_a), 0);
        chk("c2_b_q", 64'(qc_b), 0);
        tick(); #1;
        chk("c3_a_pc", 64'(fdp_a), 1);
        chk("c3_b_q", 64'(qc_b), 1);
        tick(); #1;
        chk("c4_a_pc", 64'(fdp_a), 2);
        chk("c4_b_q", 64'(qc_b), 2);

        // Backpressure on A, two-cycle flush on B with two reads in flight
        tick(); flush_b = 1'b1; ready_a = 1'b0; #1;
        chk("c5_a_pc", 64'(fdp_a), 3);
        chk("c5_a_q", 64'(qc_a), 1);
        chk("c5_a_stall", 64'(stall_a), 0);
        chk("c5_b_q", 64'(qc_b), 3);
        chk("c5_b_stall", 64'(stall_b), 0);
        tick(); #1;
        chk("c6_a_q", 64'(qc_a), 2);
        chk("c6_b_q", 64'(qc_b), 0);
        chk("c6_b_valid", 64'(fdv_b), 0);
        chk("c6_b_stall", 64'(stall_b), 0);
        tick(); flush_b = 1'b0; #1;
        chk("c7_a_q", 64'(qc_a), 3);
        chk("c7_b_q", 64'(qc_b), 0);
        tick(); #1;
        chk("c8_a_q", 64'(qc_a), 4);
        chk("c8_a_stall", 64'(stall_a), 1);
        chk("c8_a_pc", 64'(fdp_a), 3);
        chk("c8_b_q", 64'(qc_b), 0);
        tick(); #1;
        chk("c9_a_q", 64'(qc_a), 4);
        chk("c9_a_stall", 64'(stall_a), 0);
        chk("c9_b_valid", 64'(fdv_b), 0);

        // Push and pop at full on A; branch target reaches B's head
        tick(); ready_a = 1'b1; #1;
        chk("c10_a_stall", 64'(stall_a), 0);
        chk("c10_a_q", 64'(qc_a), 4);
        chk("c10_a_pc", 64'(fdp_a), 3);
        chk("c10_b_valid", 64'(fdv_b), 1);
        chk("c10_b_pc", 64'(fdp_b), 64'(TgtB));
        chk("c10_b_q", 64'(qc_b), 1);
        tick(); #1;
        chk("c11_a_q", 64'(qc_a), 4);
        chk("c11_a_pc", 64'(fdp_a), 4);
        chk("c11_b_q", 64'(qc_b), 2);
        chk("c11_b_pc", 64'(fdp_b), 64'(TgtB));
        ready_b = 1'b1;
        repeat (6) tick();

        // Reset mid-stream: first a plain pulse, then one with q_count=2
        tick(); ready_a = 1'b0; rst = 1'b1; #1;
        chk("r0_a_q", 64'(qc_a), 0);
        chk("r0_a_valid", 64'(fdv_a), 0);
        rst = 1'b0;
        tick(); #1;
        chk("r1_a_q", 64'(qc_a), 0);
        tick(); #1;
        chk("r2_a_q", 64'(qc_a), 1);
        tick(); #1;
        chk("r3_a_q", 64'(qc_a), 2);
        chk("r3_a_pc", 64'(fdp_a), 0);
        rst = 1'b1;
        #1;
        chk("async_a_q", 64'(qc_a), 0);
        chk("async_a_valid", 64'(fdv_a), 0);
        chk("async_a_stall", 64'(stall_a), 0);
        chk("async_b_q", 64'(qc_b), 0);
        rst = 1'b0;
        tick(); #1;
        chk("s1_a_q", 64'(qc_a), 0);
        chk("s1_a_valid", 64'(fdv_a), 0);
        tick(); #1;
        chk("s2_a_q", 64'(qc_a), 1);
        chk("s2_a_pc", 64'(fdp_a), 0);

        // Wrap-around with alternating decode readiness
        for (int i = 0; i < 24; i++) begin
            tick(); ready_a = (i % 2 == 0); #1;
            chk("wrap_a_q_bound", 64'(qc_a <= 3'd4), 1);
        end
        ready_a = 1'b1;
        repeat (4) tick();
        #1;
        chk("wrap_a_pops", 64'(pops_a >= 10), 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
